// File: rtl/present_key_unschedule.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// present_key_unschedule
//
// Decryption-side round-key generator for PRESENT-80. A master key is first
// walked forward through the key schedule to the round-32 register. A caller
// that already holds that register can load it directly instead. The round
// keys K32..K1 are then streamed out by running the inverse key update, one
// key per accepted handshake.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   key        in   80  master key, or round-32 register when ld_final=1
//   ld_final   in   1   1 = key is already the round-32 register
//   key_valid  in   1   load request (accepted only while key_ready=1)
//   key_ready  out  1   high in IDLE
//   rk         out  64  current round key, kreg[79:16]
//   rk_idx     out  5   round index of rk (32 is shown as 0)
//   rk_valid   out  1   rk/rk_idx valid
//   rk_ready   in   1   consumer accepts rk
//   busy       out  1   high while expanding or emitting
// -----------------------------------------------------------------------------
module present_key_unschedule #(
    parameter int ROUNDS = 31,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [79:0]       key,
    input  logic              ld_final,
    input  logic              key_valid,
    output logic              key_ready,
    output logic [63:0]       rk,
    output logic [CNT_W-1:0]  rk_idx,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    // One extra counter bit so that the round-32 index is representable.
    localparam logic [CNT_W:0] CNT_ONE   = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] CNT_LAST  = (CNT_W+1)'(ROUNDS);
    localparam logic [CNT_W:0] CNT_FINAL = (CNT_W+1)'(ROUNDS + 1);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [79:0]      r_kreg;
    logic [79:0]      w_kreg_next;
    logic [CNT_W:0]   r_cnt;
    logic [CNT_W:0]   w_cnt_next;
    logic [CNT_W:0]   w_cnt_dec;
    logic [79:0]      w_fwd_rot;
    logic [79:0]      w_fwd;
    logic [79:0]      w_inv_mix;
    logic [79:0]      w_inv;

    assign w_cnt_dec = r_cnt - CNT_ONE;

    // Forward update: rotate left 61, S-box the top nibble, XOR the counter.
    assign w_fwd_rot = {r_kreg[18:0], r_kreg[79:19]};
    always_comb begin
        w_fwd                = w_fwd_rot;
        w_fwd[79:76]         = sbox(w_fwd_rot[79:76]);
        w_fwd[15 +: CNT_W]   = w_fwd_rot[15 +: CNT_W] ^ r_cnt[CNT_W-1:0];
    end

    // Inverse update undoes the forward step that produced K(cnt) from
    // K(cnt-1), so it uses cnt-1. The XOR and S-box fields do not overlap,
    // so their order only matters relative to the rotation.
    always_comb begin
        w_inv_mix              = r_kreg;
        w_inv_mix[15 +: CNT_W] = r_kreg[15 +: CNT_W] ^ w_cnt_dec[CNT_W-1:0];
        w_inv_mix[79:76]       = sbox_inv(r_kreg[79:76]);
    end
    assign w_inv = {w_inv_mix[60:0], w_inv_mix[79:61]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_kreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_kreg  <= w_kreg_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_kreg_next  = r_kreg;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (key_valid) begin
                    w_kreg_next = key;
                    if (ld_final) begin
                        w_cnt_next   = CNT_FINAL;
                        w_state_next = ST_EMIT;
                    end else begin
                        w_cnt_next   = CNT_ONE;
                        w_state_next = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                w_kreg_next = w_fwd;
                w_cnt_next  = r_cnt + CNT_ONE;   // step at ROUNDS leaves cnt = ROUNDS+1
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (r_cnt > CNT_ONE) begin
                        w_kreg_next = w_inv;
                        w_cnt_next  = w_cnt_dec;
                    end else begin
                        // K1 consumed: drop the key material entirely.
                        w_kreg_next  = '0;
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_kreg_next  = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    assign key_ready = (r_state == ST_IDLE);
    assign rk_valid  = (r_state == ST_EMIT);
    assign busy      = (r_state != ST_IDLE);
    assign rk        = r_kreg[79:16];
    assign rk_idx    = r_cnt[CNT_W-1:0];   // 32 wraps to 0

endmodule

// File: tb/tb_present_key_unschedule.sv
`timescale 1ns/1ps
module tb_present_key_unschedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key;
    logic        ld_final;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] rk;
    logic [4:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        busy;

    present_key_unschedule dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .ld_final  (ld_final),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [79:0] kexp [1:32];

    typedef struct {
        logic [79:0] mkey;
        bit          use_final;
        bit          chk_k2;
        logic [63:0] exp_k2;
        logic [63:0] exp_k1;
        int          ready_pct;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[60 - 4*x +: 4];
    endfunction

    function automatic logic [79:0] fwd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sb(t[79:76]);
        t[19:15] = t[19:15] ^ i;
        return t;
    endfunction

    task automatic gen(input logic [79:0] m);
        kexp[1] = m;
        for (int i = 1; i <= 31; i++) kexp[i+1] = fwd(kexp[i], 5'(i));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_key_ready"}, 80'(key_ready), 80'(1));
        chk({tag, "_rk_valid"},  80'(rk_valid),  80'(0));
        chk({tag, "_busy"},      80'(busy),      80'(0));
    endtask

    // Load a key and measure edges from the load edge to the first rk_valid.
    task automatic load(input logic [79:0] k, input bit fin);
        int g = 0;
        int n = 1;
        while (!key_ready && g < 100) begin step(); g++; end
        chk("load_key_ready", 80'(key_ready), 80'(1));
        key = k; ld_final = fin; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        if (!fin) begin
            chk("expand_busy",     80'(busy),     80'(1));
            chk("expand_rk_valid", 80'(rk_valid), 80'(0));
        end
        while (!rk_valid && n < 100) begin step(); n++; end
        chk("latency", 80'(n), fin ? 80'(1) : 80'(32));
        $display("load key=%h ld_final=%0d first rk_valid after %0d edges", k, fin, n);
    endtask

    // Consume K32..K1 against kexp; rst_at>0 resets the DUT when that index is shown.
    task automatic consume(input int pct, input int rst_at, input bit chk_k2,
                           input logic [63:0] exp_k2, input logic [63:0] exp_k1);
        int e = 32;
        int guard = 0;
        bit rdy;
        logic [4:0] ei;
        while (e >= 1 && guard < 2000) begin
            guard++;
            ei = e[4:0];
            chk("rk_valid",  80'(rk_valid),  80'(1));
            chk("rk",        80'(rk),        80'(kexp[e][79:16]));
            chk("rk_idx",    80'(rk_idx),    80'(ei));
            chk("emit_busy", 80'(busy),      80'(1));
            chk("emit_key_ready", 80'(key_ready), 80'(0));
            if (chk_k2 && e == 2) chk("k2_hand", 80'(rk), 80'(exp_k2));
            if (e == 1) chk("k1_hand", 80'(rk), 80'(exp_k1));
            if (e == rst_at) begin
                rst = 1'b1; rk_ready = 1'b0;
                step();
                rst = 1'b0;
                chk_idle("rst_emit");
                chk("rst_emit_rk", 80'(rk), 80'(0));
                $display("reset at emit idx %0d", e);
                return;
            end
            rdy = ($urandom_range(0, 99) < pct);
            rk_ready = rdy;
            step();
            if (rdy) begin
                $display("beat idx=%0d rk=%h", e, kexp[e][79:16]);
                e--;
            end
        end
        rk_ready = 1'b0;
        if (e >= 1) chk("beat_timeout", 80'(e), 80'(0));
        chk_idle("after_k1");
    endtask

    initial begin
        logic [79:0] ka, kb, kb32, rk_key;
        logic [31:0] r0, r1, r2;

        vecs[0] = '{80'h0, 1'b0, 1'b1, 64'hC000000000000000, 64'h0, 100};
        vecs[1] = '{80'h0, 1'b1, 1'b1, 64'hC000000000000000, 64'h0, 100};
        vecs[2] = '{{80{1'b1}}, 1'b0, 1'b1, 64'h2FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 70};
        vecs[3] = '{80'h0000000000000000FFFF, 1'b0, 1'b1, 64'h5FFFE00000000000, 64'h0, 70};
        vecs[4] = '{{64'h0123456789ABCDEF, 16'h4567}, 1'b1, 1'b0, 64'h0, 64'h0123456789ABCDEF, 70};

        rst = 1'b1; key = '0; ld_final = 1'b0; key_valid = 1'b0; rk_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk_idle("reset");
        chk("reset_rk",     80'(rk),     80'(0));
        chk("reset_rk_idx", 80'(rk_idx), 80'(0));

        // Directed table
        for (int v = 0; v < 5; v++) begin
            gen(vecs[v].mkey);
            load(vecs[v].use_final ? kexp[32] : vecs[v].mkey, vecs[v].use_final);
            consume(vecs[v].ready_pct, 0, vecs[v].chk_k2, vecs[v].exp_k2, vecs[v].exp_k1);
        end

        // Reset during EXPAND, then a full run
        ka = {64'hDEADBEEFCAFEF00D, 16'h1234};
        gen(ka);
        key = ka; ld_final = 1'b0; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (10) step();
        chk("expand10_busy", 80'(busy), 80'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst_expand");
        chk("rst_expand_rk_idx", 80'(rk_idx), 80'(0));
        $display("reset at expand cycle 10");
        load(ka, 1'b0);
        consume(100, 0, 1'b0, 64'h0, ka[79:16]);

        // Reset during EMIT at idx 17, then a full run
        load(ka, 1'b0);
        consume(70, 17, 1'b0, 64'h0, ka[79:16]);
        load(kexp[32], 1'b1);
        consume(70, 0, 1'b0, 64'h0, ka[79:16]);

        // key_valid held high through EMIT: ignored until the cycle after K1
        kb = {64'h0F1E2D3C4B5A6978, 16'h8796};
        gen(kb);
        kb32 = kexp[32];
        gen(ka);
        load(ka, 1'b0);
        key = kb32; ld_final = 1'b1; key_valid = 1'b1;
        consume(100, 0, 1'b0, 64'h0, ka[79:16]);
        step();
        key_valid = 1'b0;
        chk("held_load_rk_valid", 80'(rk_valid), 80'(1));
        chk("held_load_rk_idx",   80'(rk_idx),   80'(0));
        gen(kb);
        consume(100, 0, 1'b0, 64'h0, kb[79:16]);

        // Random keys, alternating load mode, random backpressure
        for (int r = 0; r < 200; r++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            rk_key = {r0, r1, r2[15:0]};
            gen(rk_key);
            load(r[0] ? kexp[32] : rk_key, r[0]);
            consume(70, 0, 1'b0, 64'h0, rk_key[79:16]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
